alu_packet_proc: RTL and testbench

- Command/response engine on the far side of the UART byte stream.
- Consumes bytes from the UART receiver's AXI-Stream master and parses host command packets.
- Runs echo, 32-bit add or 32-bit multiply, then streams response bytes into the UART transmitter's AXI-Stream slave.
- Sits between uart_rx and uart_tx inside the top level, replacing the direct RX-to-TX loopback.

---
 rtl/alu_packet_proc.sv | 194 +++++++++++++++++++
 tb/tb_alu_packet_proc.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_packet_proc.sv
// Command/response engine between uart_rx and uart_tx: parses opcode/length
// packets, then echoes the payload or returns a 32-bit add/multiply result.
module alu_packet_proc #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hA0;
    localparam logic [7:0] OP_MUL  = 8'hA1;

    typedef enum logic [2:0] {
        ST_HDR0  = 3'd0,
        ST_HDR1  = 3'd1,
        ST_HDR2  = 3'd2,
        ST_HDR3  = 3'd3,
        ST_ECHO  = 3'd4,
        ST_OPND  = 3'd5,
        ST_RESP  = 3'd6,
        ST_DRAIN = 3'd7
    } state_e;

    state_e                state_q, state_d;
    logic [7:0]            opcode_q, opcode_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [23:0]           word_q, word_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic                  have_acc_q, have_acc_d;
    logic [31:0]           acc_q, acc_d;
    logic [2:0]            resp_cnt_q, resp_cnt_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  err_q, err_d;

    logic                  in_fire;
    logic                  out_fire;
    logic                  out_free;
    logic                  is_arith;
    logic [LEN_WIDTH-1:0]  len_full;
    logic [LEN_WIDTH-1:0]  pay_len;
    logic [31:0]           operand;
    logic [7:0]            resp_byte;

    // The output register can take a new byte when empty or when its byte leaves this cycle.
    assign out_free = !out_valid_q || m_axis_tready;
    assign out_fire = out_valid_q && m_axis_tready;
    assign in_fire  = s_axis_tvalid && s_axis_tready;
    assign is_arith = (opcode_q == OP_ADD) || (opcode_q == OP_MUL);
    assign len_full = LEN_WIDTH'({s_axis_tdata, len_lo_q});
    assign pay_len  = (len_full < LEN_WIDTH'(4)) ? '0 : len_full - LEN_WIDTH'(4);
    assign operand  = {s_axis_tdata, word_q};
    assign resp_byte = acc_q[{resp_cnt_q[1:0], 3'b000} +: 8];

    always_comb begin
        s_axis_tready = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_RESP: s_axis_tready = 1'b0;
                ST_ECHO: s_axis_tready = out_free;
                default: s_axis_tready = 1'b1;
            endcase
        end
    end

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through the case infers a latch.
        state_d     = state_q;
        opcode_d    = opcode_q;
        len_lo_d    = len_lo_q;
        rem_d       = rem_q;
        word_d      = word_q;
        byte_idx_d  = byte_idx_q;
        have_acc_d  = have_acc_q;
        acc_d       = acc_q;
        resp_cnt_d  = resp_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !m_axis_tready;
        err_d       = 1'b0;

        case (state_q)
            ST_HDR0: if (in_fire) begin
                opcode_d = s_axis_tdata;
                state_d  = ST_HDR1;
            end
            ST_HDR1: if (in_fire) state_d = ST_HDR2;
            ST_HDR2: if (in_fire) begin
                len_lo_d = s_axis_tdata;
                state_d  = ST_HDR3;
            end
            ST_HDR3: if (in_fire) begin
                rem_d      = pay_len;
                acc_d      = '0;
                have_acc_d = 1'b0;
                word_d     = '0;
                byte_idx_d = '0;
                resp_cnt_d = '0;
                if (opcode_q == OP_ECHO) begin
                    state_d = (pay_len == '0) ? ST_HDR0 : ST_ECHO;
                end else if (is_arith) begin
                    state_d = (pay_len == '0) ? ST_RESP : ST_OPND;
                end else begin
                    err_d   = 1'b1;
                    state_d = (pay_len == '0) ? ST_HDR0 : ST_DRAIN;
                end
            end
            ST_ECHO: if (in_fire) begin
                out_data_d  = s_axis_tdata;
                out_valid_d = 1'b1;
                rem_d       = rem_q - LEN_WIDTH'(1);
                if (rem_q == LEN_WIDTH'(1)) state_d = ST_HDR0;
            end
            ST_OPND: if (in_fire) begin
                rem_d      = rem_q - LEN_WIDTH'(1);
                byte_idx_d = byte_idx_q + 2'd1;
                case (byte_idx_q)
                    2'd0: word_d[7:0]   = s_axis_tdata;
                    2'd1: word_d[15:8]  = s_axis_tdata;
                    2'd2: word_d[23:16] = s_axis_tdata;
                    default: begin
                        // Fourth byte completes a word; the first word seeds the accumulator.
                        word_d     = '0;
                        have_acc_d = 1'b1;
                        if (!have_acc_q)              acc_d = operand;
                        else if (opcode_q == OP_ADD)  acc_d = acc_q + operand;
                        else                          acc_d = acc_q * operand;
                    end
                endcase
                if (rem_q == LEN_WIDTH'(1)) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_cnt_q != 3'd4 && out_free) begin
                    out_data_d  = resp_byte;
                    out_valid_d = 1'b1;
                    resp_cnt_d  = resp_cnt_q + 3'd1;
                end
                if (resp_cnt_q == 3'd4 && out_fire) state_d = ST_HDR0;
            end
            ST_DRAIN: if (in_fire) begin
                rem_d = rem_q - LEN_WIDTH'(1);
                if (rem_q == LEN_WIDTH'(1)) state_d = ST_HDR0;
            end
            default: state_d = ST_HDR0;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q     <= ST_HDR0;
            opcode_q    <= '0;
            len_lo_q    <= '0;
            rem_q       <= '0;
            word_q      <= '0;
            byte_idx_q  <= '0;
            have_acc_q  <= 1'b0;
            acc_q       <= '0;
            resp_cnt_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            len_lo_q    <= len_lo_d;
            rem_q       <= rem_d;
            word_q      <= word_d;
            byte_idx_q  <= byte_idx_d;
            have_acc_q  <= have_acc_d;
            acc_q       <= acc_d;
            resp_cnt_q  <= resp_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign m_axis_tdata  = out_data_q;
    assign m_axis_tvalid = out_valid_q;
    assign busy_o        = (state_q != ST_HDR0);
    assign err_o         = err_q;

endmodule

// File: tb/tb_alu_packet_proc.sv
// Scoreboard bench for alu_packet_proc: directed packets from the test plan
// plus randomized packets checked against a packet-level reference model.
module tb_alu_packet_proc;

    logic       clk_i = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b1;
    logic       busy_o;
    logic       err_o;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_err = 0;
    int err_seen = 0;
    int rdy_mode = 0;   // 0 always ready, 1 toggling, 2 random, 3 held low

    logic [7:0] exp_q [$];
    logic [7:0] pkt [$];

    alu_packet_proc #(.DATA_WIDTH(8), .LEN_WIDTH(16)) dut (
        .clk_i         (clk_i),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk_i) begin
        #2;
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            2:       m_axis_tready = ($urandom_range(0, 3) != 0);
            default: m_axis_tready = 1'b0;
        endcase
    end

    // Monitor: pops the scoreboard on every output transfer and checks held bytes stay put.
    logic       held_v = 1'b0;
    logic [7:0] held_d = 8'h00;
    logic       prev_rst = 1'b1;
    logic       err_prev = 1'b0;
    always @(negedge clk_i) begin
        logic [7:0] eb;
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL out_unexpected: got byte 0x%02h, expected no output", m_axis_tdata);
            end else begin
                eb = exp_q.pop_front();
                check("out_byte", m_axis_tdata, eb);
            end
        end
        if (held_v && !rst && !prev_rst) begin
            check("hold_valid", m_axis_tvalid, 1);
            check("hold_data", m_axis_tdata, held_d);
        end
        held_v   = m_axis_tvalid && !m_axis_tready;
        held_d   = m_axis_tdata;
        prev_rst = rst;
        if (err_o) begin
            err_seen++;
            check("err_pulse_width", err_prev, 0);
        end
        err_prev = err_o;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit taken;
        int waited;
        s_axis_tvalid = 1'b0;
        repeat (gap) begin
            @(posedge clk_i);
            #1;
        end
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        taken  = 1'b0;
        waited = 0;
        while (!taken && waited < 500) begin
            @(negedge clk_i);
            taken = s_axis_tready;
            waited++;
            @(posedge clk_i);
            #1;
        end
        s_axis_tvalid = 1'b0;
        if (!taken) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: byte 0x%02h not accepted in %0d cycles, expected acceptance", b, waited);
        end
    endtask

    task automatic send_pkt(input bit gaps);
        foreach (pkt[i])
            send_byte(pkt[i], (gaps && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    endtask

    task automatic make_hdr(input logic [7:0] op, input int len);
        pkt.delete();
        pkt.push_back(op);
        pkt.push_back(8'($urandom));
        pkt.push_back(8'(len));
        pkt.push_back(8'(len >> 8));
    endtask

    // Reference model: decodes the whole packet and queues the response it must produce.
    task automatic expect_pkt();
        int len;
        int p;
        logic [31:0] acc;
        logic [31:0] w;
        logic [63:0] prod;
        len = int'({pkt[3], pkt[2]});
        p   = (len < 4) ? 0 : len - 4;
        if (pkt[0] == 8'hEC) begin
            for (int i = 0; i < p; i++) exp_q.push_back(pkt[4 + i]);
        end else if (pkt[0] == 8'hA0 || pkt[0] == 8'hA1) begin
            acc = 32'd0;
            for (int k = 0; k < p / 4; k++) begin
                w = {pkt[4 + 4*k + 3], pkt[4 + 4*k + 2], pkt[4 + 4*k + 1], pkt[4 + 4*k]};
                if (k == 0) begin
                    acc = w;
                end else if (pkt[0] == 8'hA0) begin
                    acc = acc + w;
                end else begin
                    prod = {32'd0, acc} * {32'd0, w};
                    acc  = prod[31:0];
                end
            end
            for (int i = 0; i < 4; i++) exp_q.push_back(8'(acc >> (8 * i)));
        end else begin
            exp_err++;
        end
    endtask

    task automatic run_pkt(input bit gaps);
        expect_pkt();
        send_pkt(gaps);
    endtask

    task automatic load_pkt(input logic [7:0] bytes [$]);
        pkt = bytes;
    endtask

    task automatic wait_drain(input int limit);
        int waited = 0;
        while (exp_q.size() > 0 && waited < limit) begin
            @(negedge clk_i);
            waited++;
        end
        check("drain_left", exp_q.size(), 0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int fires;
        int waited;
        int err_before;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_s_ready", s_axis_tready, 0);
        @(posedge clk_i);
        #1 rst = 1'b0;
        @(negedge clk_i);
        check("rst_s_ready_release", s_axis_tready, 1);
        check("rst_m_valid", m_axis_tvalid, 0);
        check("rst_m_data", m_axis_tdata, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", err_o, 0);
        @(posedge clk_i);
        #1;

        // Echo with a one-cycle output latency per byte.
        rdy_mode = 0;
        load_pkt('{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43});
        expect_pkt();
        for (int i = 0; i < 4; i++) send_byte(pkt[i], 0);
        for (int i = 4; i < 7; i++) begin
            send_byte(pkt[i], 0);
            check("echo_latency_valid", m_axis_tvalid, 1);
            check("echo_latency_data", m_axis_tdata, pkt[i]);
        end
        check("echo_busy_after", busy_o, 0);
        wait_drain(50);

        // Add with wrap, then a plain add.
        load_pkt('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF});
        run_pkt(0);
        wait_drain(50);
        load_pkt('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00});
        run_pkt(0);
        wait_drain(50);

        // Multiply under toggling backpressure; input must stall for the whole response.
        rdy_mode = 1;
        load_pkt('{8'hA1, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00});
        run_pkt(0);
        fires  = 0;
        waited = 0;
        while (fires < 4 && waited < 60) begin
            @(negedge clk_i);
            check("resp_s_ready", s_axis_tready, 0);
            if (m_axis_tvalid && m_axis_tready) fires++;
            waited++;
        end
        check("mul_resp_bytes", fires, 4);
        @(posedge clk_i);
        #1 rdy_mode = 0;
        wait_drain(50);

        // Unknown opcode with payload, then an add with only trailing bytes.
        err_before = err_seen;
        load_pkt('{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB});
        run_pkt(0);
        repeat (3) @(negedge clk_i);
        check("unknown_err_pulses", err_seen - err_before, 1);
        @(posedge clk_i);
        #1;
        load_pkt('{8'hA0, 8'h00, 8'h06, 8'h00, 8'h09, 8'h09});
        run_pkt(0);
        wait_drain(50);

        // Reset after two of four response bytes have left.
        load_pkt('{8'hA0, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12});
        exp_q.push_back(8'h78);
        exp_q.push_back(8'h56);
        send_pkt(0);
        fires  = 0;
        waited = 0;
        while (fires < 2 && waited < 50) begin
            @(negedge clk_i);
            if (m_axis_tvalid && m_axis_tready) fires++;
            waited++;
        end
        check("pre_reset_bytes", fires, 2);
        @(posedge clk_i);
        #1;
        rdy_mode = 3;
        rst = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check("midrst_m_valid", m_axis_tvalid, 0);
        check("midrst_m_data", m_axis_tdata, 0);
        check("midrst_s_ready", s_axis_tready, 0);
        @(posedge clk_i);
        #1 rst = 1'b0;
        @(negedge clk_i);
        check("postrst_s_ready", s_axis_tready, 1);
        check("postrst_busy", busy_o, 0);
        @(posedge clk_i);
        #1 rdy_mode = 0;
        load_pkt('{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A});
        run_pkt(0);
        wait_drain(50);

        // Randomized packets with input gaps and random output backpressure.
        rdy_mode = 2;
        for (int n = 0; n < 40; n++) begin
            int sel;
            int p;
            logic [7:0] op;
            sel = int'($urandom_range(0, 9));
            if (sel < 3)      op = 8'hEC;
            else if (sel < 6) op = 8'hA0;
            else if (sel < 9) op = 8'hA1;
            else              op = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                make_hdr(op, int'($urandom_range(0, 3)));
            end else begin
                p = int'($urandom_range(0, 13));
                make_hdr(op, p + 4);
                for (int i = 0; i < p; i++) pkt.push_back(8'($urandom));
            end
            run_pkt(1);
        end
        wait_drain(3000);
        repeat (4) @(negedge clk_i);
        check("final_busy", busy_o, 0);
        check("err_count", err_seen, exp_err);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
